// File: rtl/counter_reg.sv
// Up-counter register with synchronous increment and synchronous clear (flush).
// The count is the register itself, so out never depends combinationally on inc/flush.
module counter_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             flush,
    output logic [width-1:0] out
);

    // Flush wins over inc; the increment wraps modulo 2^width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else if (flush)
            out <= '0;
        else if (inc)
            out <= out + width'(1);
    end

endmodule

// File: tb/tb_counter_reg.sv
// Directed and random checks of counter_reg at widths 32, 1 and 4 against a modular-arithmetic model.
module tb_counter_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        inc32, fl32, inc1, fl1, inc4, fl4;
    logic [31:0] out32;
    logic [0:0]  out1;
    logic [3:0]  out4;

    longint unsigned m32, m1, m4;
    int n_assert = 0;
    int n_fail   = 0;

    counter_reg #(.width(32)) u_c32 (.clk(clk), .rst_n(rst_n), .inc(inc32), .flush(fl32), .out(out32));
    counter_reg #(.width(1))  u_c1  (.clk(clk), .rst_n(rst_n), .inc(inc1),  .flush(fl1),  .out(out1));
    counter_reg #(.width(4))  u_c4  (.clk(clk), .rst_n(rst_n), .inc(inc4),  .flush(fl4),  .out(out4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_w32"}, 64'(out32), m32);
        chk({tag, "_w1"},  64'(out1),  m1);
        chk({tag, "_w4"},  64'(out4),  m4);
    endtask

    // Model counts as plain integers reduced modulo 2^width.
    function automatic longint unsigned next(input longint unsigned m, input logic i, input logic f,
                                             input int w);
        if (f)      return 0;
        else if (i) return (m + 1) % (64'd1 << w);
        else        return m;
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            m32 = next(m32, inc32, fl32, 32);
            m1  = next(m1,  inc1,  fl1,  1);
            m4  = next(m4,  inc4,  fl4,  4);
        end
        #1;
        chk_all(tag);
    endtask

    task automatic idle_inputs();
        {inc32, fl32, inc1, fl1, inc4, fl4} = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m32 = 0; m1 = 0; m4 = 0;
        #2;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Count to 5, then assert reset mid-cycle with inc held high.
        inc32 = 1'b1;
        repeat (5) tick("pre_rst");
        chk("cnt5", 64'(out32), 64'd5);
        @(negedge clk);
        rst_n = 1'b0;
        m32 = 0; m1 = 0; m4 = 0;
        #1;
        chk("async_rst", 64'(out32), 64'd0);
        repeat (2) tick("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("rel1");
        chk("rel1_val", 64'(out32), 64'd1);
        tick("rel2");
        chk("rel2_val", 64'(out32), 64'd2);

        // Count and hold; out must not move before the sampling edge.
        inc32 = 1'b0; fl32 = 1'b1;
        tick("clr");
        fl32 = 1'b0; inc32 = 1'b1;
        #1;
        chk("no_bypass", 64'(out32), 64'd0);
        tick("c1"); chk("c1_val", 64'(out32), 64'd1);
        tick("c2"); chk("c2_val", 64'(out32), 64'd2);
        tick("c3"); chk("c3_val", 64'(out32), 64'd3);
        inc32 = 1'b0;
        tick("h1"); chk("h1_val", 64'(out32), 64'd3);
        tick("h2"); chk("h2_val", 64'(out32), 64'd3);

        // Flush beats inc.
        inc32 = 1'b1;
        repeat (4) tick("to7");
        chk("at7", 64'(out32), 64'd7);
        fl32 = 1'b1;
        tick("prio");
        chk("prio_val", 64'(out32), 64'd0);
        fl32 = 1'b0;
        tick("after_prio");
        chk("after_prio_val", 64'(out32), 64'd1);
        idle_inputs();

        // Width 1 toggling with gaps, then flush.
        inc1 = 1'b1; tick("t1"); chk("t1_val", 64'(out1), 64'd1);
        inc1 = 1'b0; tick("g1");
        inc1 = 1'b1; tick("t2"); chk("t2_val", 64'(out1), 64'd0);
        inc1 = 1'b0; tick("g2");
        inc1 = 1'b1; tick("t3"); chk("t3_val", 64'(out1), 64'd1);
        inc1 = 1'b0; fl1 = 1'b1; tick("f1"); chk("f1_val", 64'(out1), 64'd0);
        fl1 = 1'b0;

        // Width 4 wrap.
        fl4 = 1'b1; tick("w4clr");
        fl4 = 1'b0; inc4 = 1'b1;
        repeat (15) tick("w4up");
        chk("w4_15", 64'(out4), 64'd15);
        tick("w4wrap"); chk("w4_wrap_val", 64'(out4), 64'd0);
        tick("w4_17");  chk("w4_17_val", 64'(out4), 64'd1);
        inc4 = 1'b0;

        // Two-beat writeback on the 1-bit counter.
        fl1 = 1'b1; tick("wb_clr"); chk("wb_clr_val", 64'(out1), 64'd0);
        fl1 = 1'b0; inc1 = 1'b1;
        tick("wb_beat1"); chk("wb_beat1_val", 64'(out1), 64'd1);
        tick("wb_beat2"); chk("wb_beat2_val", 64'(out1), 64'd0);
        idle_inputs();

        // Random traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            inc32 = 1'($urandom);
            inc1  = 1'($urandom);
            inc4  = 1'($urandom);
            fl32  = ($urandom_range(0, 7) == 0);
            fl1   = ($urandom_range(0, 7) == 0);
            fl4   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                m32 = 0; m1 = 0; m4 = 0;
                #1;
                chk_all("rnd_rst");
                #1;
                rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
